// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap FSM driving a clock-enable prescaler
// and an mm:ss counter pair, with a lap snapshot and a sticky wrap flag.
module stopwatch_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned MAX_SEC = 59,
  parameter int unsigned MAX_MIN = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] num,
  input  logic             btn_run,
  input  logic             btn_lap,
  input  logic             btn_clr,
  output logic [5:0]       disp_sec,
  output logic [5:0]       disp_min,
  output logic             running,
  output logic             lap_active,
  output logic             tick,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_sec;
  logic [5:0]       r_min;
  logic [5:0]       r_snap_sec;
  logic [5:0]       r_snap_min;
  logic [5:0]       r_disp_sec;
  logic [5:0]       r_disp_min;
  logic             r_running;
  logic             r_lap_active;
  logic             r_tick;
  logic             r_ovf;

  state_t           w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [5:0]       w_sec;
  logic [5:0]       w_min;
  logic [5:0]       w_snap_sec;
  logic [5:0]       w_snap_min;
  logic             w_take_snap;
  logic             w_active;
  logic             w_last;
  logic             w_tick;
  logic             w_ovf;

  always_comb begin
    w_state     = r_state;
    w_take_snap = 1'b0;
    w_cnt       = r_cnt;
    w_tick      = 1'b0;
    w_sec       = r_sec;
    w_min       = r_min;
    w_ovf       = r_ovf;
    w_snap_sec  = r_snap_sec;
    w_snap_min  = r_snap_min;
    w_active    = (r_state == S_RUN) || (r_state == S_LAP);
    // num of 0 or 1 means a tick on every running cycle
    w_last      = (num <= CNT_W'(1)) || (r_cnt >= (num - CNT_W'(1)));

    // Strobe priority: clr > run > lap
    case (r_state)
      S_IDLE: begin
        if (!btn_clr && btn_run) w_state = S_RUN;
      end
      S_RUN: begin
        if (btn_clr)      w_state = S_IDLE;
        else if (btn_run) w_state = S_PAUSE;
        else if (btn_lap) begin
          w_state     = S_LAP;
          w_take_snap = 1'b1;
        end
      end
      S_PAUSE: begin
        if (btn_clr)      w_state = S_IDLE;
        else if (btn_run) w_state = S_RUN;
      end
      S_LAP: begin
        if (btn_clr)      w_state = S_IDLE;
        else if (btn_run) w_state = S_PAUSE;
        else if (btn_lap) w_state = S_RUN;
      end
    endcase

    if (btn_clr) begin
      w_cnt = '0;
    end else if (w_active) begin
      if (w_last) begin
        w_cnt  = '0;
        w_tick = 1'b1;
      end else begin
        w_cnt = r_cnt + CNT_W'(1);
      end
    end

    if (btn_clr) begin
      w_sec = '0;
      w_min = '0;
      w_ovf = 1'b0;
    end else if (r_tick) begin
      if (r_sec < 6'(MAX_SEC)) begin
        w_sec = r_sec + 6'd1;
      end else begin
        w_sec = '0;
        if (r_min < 6'(MAX_MIN)) begin
          w_min = r_min + 6'd1;
        end else begin
          w_min = '0;
          w_ovf = 1'b1;
        end
      end
    end

    // Snapshot captures the pre-increment live value
    if (w_take_snap) begin
      w_snap_sec = r_sec;
      w_snap_min = r_min;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sec        <= '0;
      r_min        <= '0;
      r_snap_sec   <= '0;
      r_snap_min   <= '0;
      r_disp_sec   <= '0;
      r_disp_min   <= '0;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
      r_tick       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_sec        <= w_sec;
      r_min        <= w_min;
      r_snap_sec   <= w_snap_sec;
      r_snap_min   <= w_snap_min;
      r_disp_sec   <= (w_state == S_LAP) ? w_snap_sec : w_sec;
      r_disp_min   <= (w_state == S_LAP) ? w_snap_min : w_min;
      r_running    <= (w_state == S_RUN) || (w_state == S_LAP);
      r_lap_active <= (w_state == S_LAP);
      r_tick       <= w_tick;
      r_ovf        <= w_ovf;
    end
  end

  assign disp_sec   = r_disp_sec;
  assign disp_min   = r_disp_min;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign tick       = r_tick;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table, directed corner
// sequences and random strobes against an elapsed-seconds reference model.
module tb_stopwatch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] num;
  logic        btn_run;
  logic        btn_lap;
  logic        btn_clr;
  logic [5:0]  disp_sec;
  logic [5:0]  disp_min;
  logic        running;
  logic        lap_active;
  logic        tick;
  logic        ovf;

  stopwatch_ctrl #(.CNT_W(32), .MAX_SEC(59), .MAX_MIN(59)) dut (
    .clk(clk), .rst_n(rst_n), .num(num),
    .btn_run(btn_run), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .disp_sec(disp_sec), .disp_min(disp_min), .running(running),
    .lap_active(lap_active), .tick(tick), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: modes, total elapsed seconds, second-phase counter
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
  int     m_mode;
  int     m_total;
  int     m_snap;
  longint m_phase;
  bit     m_tick;
  bit     m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_total = 0; m_snap = 0; m_phase = 0; m_tick = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit r, input bit l, input bit c);
    int     old;
    bit     counting;
    longint n;
    old      = m_mode;
    counting = (old == M_RUN) || (old == M_LAP);
    n        = longint'(num);
    if (!c && !r && l && old == M_RUN) m_snap = m_total;
    if (c) begin
      m_total = 0;
      m_ovf   = 0;
    end else if (m_tick) begin
      m_total = (m_total + 1) % 3600;
      if (m_total == 0) m_ovf = 1;
    end
    if (c) begin
      m_phase = 0;
      m_tick  = 0;
    end else if (counting) begin
      if (n <= 1 || m_phase >= n - 1) begin
        m_phase = 0;
        m_tick  = 1;
      end else begin
        m_phase++;
        m_tick = 0;
      end
    end else begin
      m_tick = 0;
    end
    if (c)      m_mode = M_IDLE;
    else if (r) m_mode = counting ? M_PAUSE : M_RUN;
    else if (l) begin
      if (old == M_RUN)      m_mode = M_LAP;
      else if (old == M_LAP) m_mode = M_RUN;
    end
  endtask

  task automatic compare_model();
    int          t;
    logic [31:0] exp;
    t   = (m_mode == M_LAP) ? m_snap : m_total;
    exp = {16'd0, 6'(t % 60), 6'(t / 60), (m_mode == M_RUN || m_mode == M_LAP),
           (m_mode == M_LAP), m_tick, m_ovf};
    check("model", {16'd0, disp_sec, disp_min, running, lap_active, tick, ovf}, exp);
  endtask

  task automatic step(input logic r, input logic l, input logic c);
    btn_run = r; btn_lap = l; btn_clr = c;
    @(posedge clk);
    model_step(r, l, c);
    #1;
    btn_run = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
    compare_model();
  endtask

  typedef struct {
    logic       run;
    logic       lap;
    logic       clr;
    logic [5:0] sec;
    logic       run_o;
    logic       lap_o;
    logic       tick_o;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // num = 1: tick on every running cycle; sec visible the cycle after tick
    vecs[0]  = '{1, 0, 0, 6'd0, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 6'd0, 1, 0, 1};
    vecs[2]  = '{0, 0, 0, 6'd1, 1, 0, 1};
    vecs[3]  = '{0, 0, 0, 6'd2, 1, 0, 1};
    vecs[4]  = '{0, 1, 0, 6'd2, 1, 1, 1};
    vecs[5]  = '{0, 0, 0, 6'd2, 1, 1, 1};
    vecs[6]  = '{0, 1, 0, 6'd5, 1, 0, 1};
    vecs[7]  = '{1, 0, 0, 6'd6, 0, 0, 1};
    vecs[8]  = '{0, 0, 0, 6'd7, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 6'd7, 0, 0, 0};
    vecs[10] = '{0, 1, 0, 6'd7, 0, 0, 0};
    vecs[11] = '{1, 0, 0, 6'd7, 1, 0, 0};
    vecs[12] = '{1, 0, 1, 6'd0, 0, 0, 0};
    vecs[13] = '{0, 0, 1, 6'd0, 0, 0, 0};

    btn_run = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
    num = 32'd1;
    rst_n = 1'b0;
    model_reset();
    #12;
    check("reset_outputs", {26'd0, disp_sec}, 32'd0);
    check("reset_status", {26'd0, disp_min, running, lap_active, tick, ovf}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].run, vecs[i].lap, vecs[i].clr);
      check($sformatf("vec%0d", i),
            {23'd0, disp_sec, running, lap_active, tick},
            {23'd0, vecs[i].sec, vecs[i].run_o, vecs[i].lap_o, vecs[i].tick_o});
    end

    // Prescaler: num=4 gives a tick every 4th running cycle
    num = 32'd4;
    step(1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      for (int j = 1; j <= 4; j++) begin
        step(0, 0, 0);
        if (j == 1 && k > 1) check("presc_sec", {26'd0, disp_sec}, 32'(k - 1));
        check("presc_tick", {31'd0, tick}, {31'd0, (j == 4)});
      end
    end
    step(0, 0, 0);
    check("presc_sec3", {26'd0, disp_sec}, 32'd3);

    // Pause keeps a partial second: 6 clks before, 4 clks after resume
    step(0, 0, 1);
    num = 32'd10;
    step(1, 0, 0);
    for (int j = 0; j < 5; j++) step(0, 0, 0);
    step(1, 0, 0);
    for (int j = 0; j < 3; j++) begin
      step(0, 0, 0);
      check("pause_hold", {30'd0, running, tick}, 32'd0);
    end
    step(1, 0, 0);
    for (int j = 1; j <= 4; j++) begin
      step(0, 0, 0);
      check("resume_tick", {31'd0, tick}, {31'd0, (j == 4)});
    end

    // Wrap: 60 ticks -> 01:00, 3600 ticks -> 00:00 with ovf
    step(0, 0, 1);
    num = 32'd1;
    step(1, 0, 0);
    for (int n = 1; n <= 3601; n++) begin
      step(0, 0, 0);
      if (n == 61)
        check("wrap_min", {19'd0, disp_min, disp_sec, ovf}, {19'd0, 6'd1, 6'd0, 1'b0});
      if (n == 3601)
        check("wrap_ovf", {19'd0, disp_min, disp_sec, ovf}, {19'd0, 6'd0, 6'd0, 1'b1});
    end

    // Priority from LAP: clr beats run and lap, clears ovf
    step(0, 1, 0);
    check("prio_in_lap", {31'd0, lap_active}, 32'd1);
    step(1, 1, 1);
    check("prio_clr", {18'd0, disp_sec, disp_min, ovf, running},
          {18'd0, 6'd0, 6'd0, 1'b0, 1'b0});

    // Lap freeze at 00:05, release at live 00:09
    num = 32'd4;
    step(1, 0, 0);
    for (int i = 0; i < 100 && m_total != 5; i++) step(0, 0, 0);
    check("lap_reach5", {26'd0, disp_sec}, 32'd5);
    step(0, 1, 0);
    check("lap_freeze", {24'd0, disp_sec, running, lap_active}, {24'd0, 6'd5, 1'b1, 1'b1});
    for (int i = 0; i < 100 && m_total != 9; i++) begin
      step(0, 0, 0);
      check("lap_hold", {25'd0, disp_sec, running}, {25'd0, 6'd5, 1'b1});
    end
    step(0, 1, 0);
    check("lap_release", {25'd0, disp_sec, lap_active}, {25'd0, 6'd9, 1'b0});

    // Async reset mid-run at 00:07
    step(0, 0, 1);
    num = 32'd1;
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    check("pre_reset_sec", {26'd0, disp_sec}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {16'd0, disp_sec, disp_min, running, lap_active, tick, ovf}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    step(0, 0, 0);
    check("post_reset_idle", {31'd0, running}, 32'd0);

    // Random strobes and live num changes against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) num = 32'($urandom_range(0, 6));
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
